// File: rtl/cache_pkg.sv
// rtl/cache_pkg.sv - shared state type, default geometry and helpers for set_assoc_cache
package cache_pkg;

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        SWAP_OUT   = 2'd1,
        SWAP_IN    = 2'd2,
        SWAP_IN_OK = 2'd3
    } cache_state_t;

    localparam int DEF_LINE_ADDR_LEN = 3;
    localparam int DEF_SET_ADDR_LEN  = 3;
    localparam int DEF_TAG_ADDR_LEN  = 6;
    localparam int DEF_WAY_CNT       = 4;

    // A direct-mapped cache still needs a 1-bit way/age field to keep vectors legal.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/cache_lru.sv
// rtl/cache_lru.sv - per-set LRU age update and victim selection
module cache_lru
    import cache_pkg::*;
#(
    parameter int WAY_CNT = DEF_WAY_CNT,
    parameter int AW      = idx_width(WAY_CNT)
) (
    input  logic [WAY_CNT-1:0][AW-1:0] i_ages,
    input  logic [WAY_CNT-1:0]         i_valid,
    input  logic [AW-1:0]              i_acc_way,
    output logic [WAY_CNT-1:0][AW-1:0] o_ages_next,
    output logic [AW-1:0]              o_victim
);

    logic [AW-1:0] w_acc_age;
    logic [AW-1:0] w_inv_way;
    logic [AW-1:0] w_lru_way;
    logic [AW-1:0] w_max_age;
    logic          w_any_inv;

    always_comb begin
        w_acc_age = i_ages[i_acc_way];
        for (int w = 0; w < WAY_CNT; w++) begin
            if (AW'(w) == i_acc_way) begin
                o_ages_next[w] = '0;
            end else if (i_ages[w] < w_acc_age) begin
                o_ages_next[w] = i_ages[w] + 1'b1;
            end else begin
                o_ages_next[w] = i_ages[w];
            end
        end
    end

    // Empty ways are always filled before anything valid is displaced.
    always_comb begin
        w_any_inv = 1'b0;
        w_inv_way = '0;
        w_lru_way = '0;
        w_max_age = '0;
        for (int w = WAY_CNT - 1; w >= 0; w--) begin
            if (!i_valid[w]) begin
                w_any_inv = 1'b1;
                w_inv_way = AW'(w);
            end
        end
        for (int w = 0; w < WAY_CNT; w++) begin
            if (i_ages[w] >= w_max_age) begin
                w_max_age = i_ages[w];
                w_lru_way = AW'(w);
            end
        end
        o_victim = w_any_inv ? w_inv_way : w_lru_way;
    end

endmodule

// File: rtl/set_assoc_cache.sv
// rtl/set_assoc_cache.sv - write-back set-associative cache with LRU replacement
// Optional hit/miss counters are enabled with CACHE_STATS_EN.
module set_assoc_cache
    import cache_pkg::*;
#(
    parameter int LINE_ADDR_LEN = DEF_LINE_ADDR_LEN,
    parameter int SET_ADDR_LEN  = DEF_SET_ADDR_LEN,
    parameter int TAG_ADDR_LEN  = DEF_TAG_ADDR_LEN,
    parameter int WAY_CNT       = DEF_WAY_CNT
) (
    input  logic                                 clk,
    input  logic                                 rst_n,
    input  logic [31:0]                          addr,
    input  logic                                 rd_req,
    input  logic                                 wr_req,
    input  logic [31:0]                          wr_data,
    output logic [31:0]                          rd_data,
    output logic                                 miss,
    output logic [TAG_ADDR_LEN+SET_ADDR_LEN-1:0] mem_addr,
    output logic                                 mem_rd_req,
    output logic                                 mem_wr_req,
    output logic [32*(2**LINE_ADDR_LEN)-1:0]     mem_wr_line,
    input  logic [32*(2**LINE_ADDR_LEN)-1:0]     mem_rd_line,
    input  logic                                 mem_gnt
`ifdef CACHE_STATS_EN
    ,
    output logic [31:0]                          hit_cnt,
    output logic [31:0]                          miss_cnt
`endif
);

    localparam int SET_SIZE = 2 ** SET_ADDR_LEN;
    localparam int LINE_W   = 32 * (2 ** LINE_ADDR_LEN);
    localparam int AW       = idx_width(WAY_CNT);

    cache_state_t r_state;
    cache_state_t w_state_nxt;

    logic [LINE_W-1:0]         r_data  [SET_SIZE][WAY_CNT];
    logic [TAG_ADDR_LEN-1:0]   r_tag   [SET_SIZE][WAY_CNT];
    logic [WAY_CNT-1:0]        r_valid [SET_SIZE];
    logic [WAY_CNT-1:0]        r_dirty [SET_SIZE];
    logic [WAY_CNT-1:0][AW-1:0] r_ages [SET_SIZE];

    logic [AW-1:0]             r_victim;
    logic [SET_ADDR_LEN-1:0]   r_set;
    logic [TAG_ADDR_LEN-1:0]   r_fill_tag;
    logic [LINE_W-1:0]         r_fill_line;

    logic [LINE_ADDR_LEN-1:0]  w_line;
    logic [SET_ADDR_LEN-1:0]   w_set;
    logic [TAG_ADDR_LEN-1:0]   w_tag;
    logic [31:0]               w_addr_unused;
    logic                      w_req;
    logic                      w_hit;
    logic [AW-1:0]             w_hit_way;
    logic                      w_serve;
    logic                      w_swap_start;
    logic [LINE_W-1:0]         w_hit_line;
    logic [SET_ADDR_LEN-1:0]   w_lru_set;
    logic [AW-1:0]             w_lru_way;
    logic [WAY_CNT-1:0][AW-1:0] w_ages_nxt;
    logic [AW-1:0]             w_victim;

    assign w_line        = addr[2 +: LINE_ADDR_LEN];
    assign w_set         = addr[2 + LINE_ADDR_LEN +: SET_ADDR_LEN];
    assign w_tag         = addr[2 + LINE_ADDR_LEN + SET_ADDR_LEN +: TAG_ADDR_LEN];
    assign w_addr_unused = addr;

    always_comb begin
        w_hit     = 1'b0;
        w_hit_way = '0;
        for (int w = 0; w < WAY_CNT; w++) begin
            if (r_valid[w_set][w] && (r_tag[w_set][w] == w_tag)) begin
                w_hit     = 1'b1;
                w_hit_way = AW'(w);
            end
        end
    end

    assign w_req      = rd_req | wr_req;
    assign w_serve    = w_req & w_hit & (r_state == IDLE);
    assign miss       = w_req & ~(w_hit & (r_state == IDLE));
    assign w_hit_line = r_data[w_set][w_hit_way];
    assign rd_data    = w_hit_line[{w_line, 5'b0} +: 32];
    assign mem_wr_line = r_data[r_set][r_victim];

    // The single LRU port serves the CPU hit in IDLE and the fill in SWAP_IN_OK.
    assign w_lru_set = (r_state == SWAP_IN_OK) ? r_set : w_set;
    assign w_lru_way = (r_state == SWAP_IN_OK) ? r_victim : w_hit_way;

    cache_lru #(
        .WAY_CNT (WAY_CNT),
        .AW      (AW)
    ) u_lru (
        .i_ages      (r_ages[w_lru_set]),
        .i_valid     (r_valid[w_set]),
        .i_acc_way   (w_lru_way),
        .o_ages_next (w_ages_nxt),
        .o_victim    (w_victim)
    );

    always_comb begin
        w_state_nxt  = r_state;
        w_swap_start = 1'b0;
        mem_rd_req   = 1'b0;
        mem_wr_req   = 1'b0;
        mem_addr     = '0;
        case (r_state)
            IDLE: begin
                if (w_req && !w_hit) begin
                    w_swap_start = 1'b1;
                    w_state_nxt  = (r_valid[w_set][w_victim] && r_dirty[w_set][w_victim])
                                   ? SWAP_OUT : SWAP_IN;
                end
            end
            SWAP_OUT: begin
                mem_wr_req = 1'b1;
                mem_addr   = {r_tag[r_set][r_victim], r_set};
                if (mem_gnt) w_state_nxt = SWAP_IN;
            end
            SWAP_IN: begin
                mem_rd_req = 1'b1;
                mem_addr   = {r_fill_tag, r_set};
                if (mem_gnt) w_state_nxt = SWAP_IN_OK;
            end
            SWAP_IN_OK: w_state_nxt = IDLE;
            default:    w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= IDLE;
            r_victim   <= '0;
            r_set      <= '0;
            r_fill_tag <= '0;
            for (int s = 0; s < SET_SIZE; s++) begin
                r_valid[s] <= '0;
                r_dirty[s] <= '0;
                for (int w = 0; w < WAY_CNT; w++) begin
                    r_ages[s][w] <= AW'(w);
                end
            end
        end else begin
            r_state <= w_state_nxt;
            if (w_swap_start) begin
                r_victim   <= w_victim;
                r_set      <= w_set;
                r_fill_tag <= w_tag;
            end
            if (w_serve) begin
                r_ages[w_set] <= w_ages_nxt;
                if (wr_req) r_dirty[w_set][w_hit_way] <= 1'b1;
            end
            if (r_state == SWAP_IN_OK) begin
                r_ages[r_set]            <= w_ages_nxt;
                r_valid[r_set][r_victim] <= 1'b1;
                r_dirty[r_set][r_victim] <= 1'b0;
            end
        end
    end

    // Line storage carries no reset; validity alone decides what can hit.
    always_ff @(posedge clk) begin
        if ((r_state == SWAP_IN) && mem_gnt) begin
            r_fill_line <= mem_rd_line;
        end
        if (r_state == SWAP_IN_OK) begin
            r_data[r_set][r_victim] <= r_fill_line;
            r_tag[r_set][r_victim]  <= r_fill_tag;
        end else if (w_serve && wr_req) begin
            r_data[w_set][w_hit_way][{w_line, 5'b0} +: 32] <= wr_data;
        end
    end

`ifdef CACHE_STATS_EN
    logic [31:0] r_hit_cnt;
    logic [31:0] r_miss_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_hit_cnt  <= '0;
            r_miss_cnt <= '0;
        end else begin
            if (w_serve)      r_hit_cnt  <= r_hit_cnt + 32'd1;
            if (w_swap_start) r_miss_cnt <= r_miss_cnt + 32'd1;
        end
    end

    assign hit_cnt  = r_hit_cnt;
    assign miss_cnt = r_miss_cnt;
`endif

endmodule

// File: tb/tb_set_assoc_cache.sv
// tb/tb_set_assoc_cache.sv - randomized and directed bench for set_assoc_cache against a recency-list model
module tb_set_assoc_cache;

    localparam int WORDS = 8;
    localparam int SETS  = 8;
    localparam int WAYS  = 4;
    localparam int LW    = 32 * WORDS;

    logic          clk         = 1'b0;
    logic          rst_n       = 1'b0;
    logic [31:0]   addr        = '0;
    logic          rd_req      = 1'b0;
    logic          wr_req      = 1'b0;
    logic [31:0]   wr_data     = '0;
    logic [31:0]   rd_data;
    logic          miss;
    logic [8:0]    mem_addr;
    logic          mem_rd_req;
    logic          mem_wr_req;
    logic [LW-1:0] mem_wr_line;
    logic [LW-1:0] mem_rd_line = '0;
    logic          mem_gnt     = 1'b0;
`ifdef CACHE_STATS_EN
    logic [31:0]   hit_cnt;
    logic [31:0]   miss_cnt;
`endif

    set_assoc_cache dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .addr        (addr),
        .rd_req      (rd_req),
        .wr_req      (wr_req),
        .wr_data     (wr_data),
        .rd_data     (rd_data),
        .miss        (miss),
        .mem_addr    (mem_addr),
        .mem_rd_req  (mem_rd_req),
        .mem_wr_req  (mem_wr_req),
        .mem_wr_line (mem_wr_line),
        .mem_rd_line (mem_rd_line),
        .mem_gnt     (mem_gnt)
`ifdef CACHE_STATS_EN
        ,
        .hit_cnt     (hit_cnt),
        .miss_cnt    (miss_cnt)
`endif
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Backing memory and the cache model: per-set recency list, MRU first.
    logic [LW-1:0] mem     [512];
    logic [LW-1:0] m_line  [SETS][WAYS];
    int            m_tag   [SETS][WAYS];
    bit            m_valid [SETS][WAYS];
    bit            m_dirty [SETS][WAYS];
    int            m_order [SETS][$];
    int            exp_hits;
    int            exp_misses;

    task automatic check_eq(input string name, input logic [LW-1:0] got, input logic [LW-1:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    function automatic void model_reset();
        for (int s = 0; s < SETS; s++) begin
            m_order[s].delete();
            for (int w = 0; w < WAYS; w++) begin
                m_valid[s][w] = 1'b0;
                m_dirty[s][w] = 1'b0;
                m_order[s].push_back(w);
            end
        end
        exp_hits   = 0;
        exp_misses = 0;
    endfunction

    function automatic void touch(input int s, input int w);
        for (int i = 0; i < m_order[s].size(); i++) begin
            if (m_order[s][i] == w) begin
                m_order[s].delete(i);
                break;
            end
        end
        m_order[s].push_front(w);
    endfunction

    // Entered and left half a cycle before a rising edge; acts as the memory while the cache stalls.
    task automatic access(input logic [31:0] a, input bit wr, input logic [31:0] wd,
                          input string nm, output bit dut_hit, output bit saw_wb);
        int s, t, wi, hw, vic, n;
        bit m_hit, exp_wb, rd_seen, done;
        logic [8:0] fa, wba;
        wi = int'((a / 4) % WORDS);
        s  = int'((a / 32) % SETS);
        t  = int'((a / 256) % 64);
        m_hit = 1'b0;
        hw    = 0;
        for (int w = 0; w < WAYS; w++) begin
            if (m_valid[s][w] && m_tag[s][w] == t) begin
                m_hit = 1'b1;
                hw    = w;
            end
        end
        vic = -1;
        for (int w = 0; w < WAYS; w++) begin
            if (!m_valid[s][w] && vic < 0) vic = w;
        end
        if (vic < 0) vic = m_order[s][m_order[s].size() - 1];
        exp_wb = !m_hit && m_valid[s][vic] && m_dirty[s][vic];
        wba    = 9'(m_tag[s][vic] * SETS + s);
        fa     = 9'(t * SETS + s);

        addr = a; rd_req = !wr; wr_req = wr; wr_data = wd;
        #1;
        dut_hit = !miss;
        check_eq({nm, "_first_miss"}, miss, !m_hit);

        n = 0; done = 1'b0; saw_wb = 1'b0; rd_seen = 1'b0;
        while (!done && n < 100) begin
            if (!miss) begin
                done = 1'b1;
            end else begin
                if (mem_wr_req) begin
                    if (!saw_wb) begin
                        check_eq({nm, "_wb_addr"}, mem_addr, wba);
                        check_eq({nm, "_wb_line"}, mem_wr_line, m_line[s][vic]);
                    end
                    saw_wb = 1'b1;
                    if ($urandom_range(0, 3) != 0) begin
                        mem[mem_addr] = mem_wr_line;
                        mem_gnt = 1'b1;
                    end
                end else if (mem_rd_req) begin
                    if (!rd_seen) begin
                        check_eq({nm, "_fill_addr"}, mem_addr, fa);
                        check_eq({nm, "_wb_before_rd"}, saw_wb, exp_wb);
                    end
                    rd_seen = 1'b1;
                    mem_rd_line = mem[mem_addr];
                    if ($urandom_range(0, 3) != 0) mem_gnt = 1'b1;
                end
                @(negedge clk);
                mem_gnt = 1'b0;
                #1;
                n++;
            end
        end
        check_eq({nm, "_served"}, done, 1'b1);

        if (done) begin
            if (!m_hit) begin
                m_line[s][vic]  = mem[fa];
                m_tag[s][vic]   = t;
                m_valid[s][vic] = 1'b1;
                m_dirty[s][vic] = 1'b0;
                touch(s, vic);
                hw = vic;
                exp_misses++;
                check_eq({nm, "_fill_seen"}, rd_seen, 1'b1);
            end
            if (!wr) begin
                check_eq({nm, "_rd_data"}, rd_data, m_line[s][hw][wi*32 +: 32]);
            end else begin
                m_line[s][hw][wi*32 +: 32] = wd;
                m_dirty[s][hw] = 1'b1;
            end
            touch(s, hw);
            exp_hits++;
        end
        @(negedge clk);
        rd_req = 1'b0; wr_req = 1'b0;
        #1;
    endtask

    initial begin
        bit h, wb;
        logic [31:0] ra, rd;

        for (int i = 0; i < 512; i++) begin
            for (int k = 0; k < WORDS; k++) mem[i][k*32 +: 32] = $urandom();
        end
        model_reset();

        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        #1;
        check_eq("rst_miss_idle", miss, 1'b0);
        check_eq("rst_mem_rd_req", mem_rd_req, 1'b0);
        check_eq("rst_mem_wr_req", mem_wr_req, 1'b0);
        check_eq("rst_mem_addr", mem_addr, 9'd0);
        rd_req = 1'b1;
        #1;
        check_eq("rst_miss_on_req", miss, 1'b1);
        rd_req = 1'b0;
        #1;

        // Cold read, then write hit and read-back in the same line
        access(32'h100, 1'b0, 32'h0, "cold_rd", h, wb);
        check_eq("cold_rd_was_miss", h, 1'b0);
        access(32'h104, 1'b1, 32'hDEADBEEF, "wr_hit", h, wb);
        check_eq("wr_hit_hit", h, 1'b1);
        access(32'h104, 1'b0, 32'h0, "rd_after_wr", h, wb);
        check_eq("rd_after_wr_hit", h, 1'b1);

        // Fill set 0 with three more tags; a fifth tag evicts the dirty first line
        access(32'h200, 1'b0, 32'h0, "s0_t2", h, wb);
        access(32'h300, 1'b0, 32'h0, "s0_t3", h, wb);
        access(32'h400, 1'b0, 32'h0, "s0_t4", h, wb);
        access(32'h500, 1'b0, 32'h0, "s0_t5", h, wb);
        check_eq("s0_t5_wrote_back", wb, 1'b1);
        rd = mem[8][63:32];
        check_eq("s0_wb_mem_word", rd, 32'hDEADBEEF);
        access(32'h100, 1'b0, 32'h0, "s0_t1_again", h, wb);
        check_eq("s0_t1_evicted", h, 1'b0);

        // LRU order in set 1: A B C D, A, E must displace B
        for (int t = 8; t <= 11; t++) access(32'(t * 256 + 32), 1'b0, 32'h0, "s1_fill", h, wb);
        access(32'(8 * 256 + 32), 1'b0, 32'h0, "s1_A_again", h, wb);
        check_eq("s1_A_rehit", h, 1'b1);
        access(32'(12 * 256 + 32), 1'b0, 32'h0, "s1_E", h, wb);
        access(32'(8 * 256 + 32), 1'b0, 32'h0, "s1_A_kept", h, wb);
        check_eq("s1_A_kept_hit", h, 1'b1);
        access(32'(9 * 256 + 32), 1'b0, 32'h0, "s1_B_gone", h, wb);
        check_eq("s1_B_evicted", h, 1'b0);

        for (int i = 0; i < 400; i++) begin
            ra = ($urandom_range(0, 5) << 8) | ($urandom_range(0, 3) << 5) | ($urandom_range(0, 7) << 2);
            access(ra, 1'($urandom_range(0, 1)), $urandom(), "rnd", h, wb);
        end

        // Make set 2 fully dirty, start a write-back and reset while it is pending
        for (int t = 20; t <= 23; t++) access(32'(t * 256 + 64), 1'b1, $urandom(), "s2_dirty", h, wb);
        addr = 32'(24 * 256 + 64); wr_data = 32'h12345678; wr_req = 1'b1;
        #1;
        check_eq("so_miss", miss, 1'b1);
        @(negedge clk);
        #1;
        check_eq("so_mem_wr_req", mem_wr_req, 1'b1);
        rst_n = 1'b0;
        #1;
        check_eq("so_rst_wr_req", mem_wr_req, 1'b0);
        check_eq("so_rst_rd_req", mem_rd_req, 1'b0);
        check_eq("so_rst_mem_addr", mem_addr, 9'd0);
        check_eq("so_rst_miss", miss, 1'b1);
        wr_req = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        #1;
        check_eq("post_rst_wr_req", mem_wr_req, 1'b0);
        check_eq("post_rst_rd_req", mem_rd_req, 1'b0);
        check_eq("post_rst_miss", miss, 1'b0);

        // Three misses and two plain hits after the reset
        access(32'(20 * 256 + 64), 1'b0, 32'h0, "post_rst_old", h, wb);
        check_eq("post_rst_old_miss", h, 1'b0);
        access(32'(21 * 256 + 64), 1'b0, 32'h0, "post_rst_t21", h, wb);
        access(32'(22 * 256 + 68), 1'b0, 32'h0, "post_rst_t22", h, wb);
        access(32'(20 * 256 + 72), 1'b0, 32'h0, "post_rst_t20", h, wb);
        access(32'(21 * 256 + 76), 1'b1, 32'hCAFEF00D, "post_rst_t21w", h, wb);
`ifdef CACHE_STATS_EN
        check_eq("stats_miss_cnt", miss_cnt, 32'(exp_misses));
        check_eq("stats_hit_cnt", hit_cnt, 32'(exp_hits));
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/set_assoc_cache.md
SET_ASSOC_CACHE -- requirements
Module: set_assoc_cache

Interface
REQ-001 SHALL have parameter LINE_ADDR_LEN, default 3, giving log2 of words per line.
REQ-002 SHALL have parameter SET_ADDR_LEN, default 3, giving log2 of set count.
REQ-003 SHALL have parameter TAG_ADDR_LEN, default 6, giving tag width.
REQ-004 SHALL have parameter WAY_CNT, default 4, giving ways per set; legal values are powers of two from 1 to 8.
REQ-005 SHALL use one clock and an asynchronous, active-low reset.
REQ-006 SHALL have port clk, input, 1 bit: the single clock, rising edge.
REQ-007 SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-008 SHALL have port addr, input, 32 bits: byte address, split as {unused, tag, set, line, word[1:0]}.
REQ-009 SHALL have port rd_req, input, 1 bit: CPU read request.
REQ-010 SHALL have port wr_req, input, 1 bit: CPU write request.
REQ-011 SHALL have port wr_data, input, 32 bits: CPU write word.
REQ-012 SHALL have port rd_data, output, 32 bits: combinational word selected by addr in the hit way.
REQ-013 SHALL have port miss, output, 1 bit: CPU stall, high while a request is not served this cycle.
REQ-014 SHALL have port mem_addr, output, TAG_ADDR_LEN+SET_ADDR_LEN bits: line address to memory.
REQ-015 SHALL have ports mem_rd_req and mem_wr_req, outputs, 1 bit each: line read and line write requests.
REQ-016 SHALL have port mem_wr_line, output, 32*2^LINE_ADDR_LEN bits: packed eviction line, word 0 in the LSBs.
REQ-017 SHALL have port mem_rd_line, input, 32*2^LINE_ADDR_LEN bits: packed fill line.
REQ-018 SHALL have port mem_gnt, input, 1 bit: single-cycle memory completion pulse.

Function
REQ-019 SHALL declare a hit when any way of the addressed set is valid with a matching tag; at most one way SHALL match.
REQ-020 SHALL drive miss = (rd_req|wr_req) & ~(hit & state==IDLE).
REQ-021 SHALL, on a write hit in IDLE, write wr_data at the next edge, set that way's dirty bit and mark the way MRU.
REQ-022 SHALL, on a read hit in IDLE, mark the way MRU with zero added latency.
REQ-023 SHALL use a 4-state machine with states IDLE, SWAP_OUT, SWAP_IN and SWAP_IN_OK.
REQ-024 SHALL, on a miss in IDLE, select a victim: the lowest-index invalid way, otherwise the LRU way; the victim index and fill address SHALL be latched.
REQ-025 SHALL go from IDLE to SWAP_OUT when the victim is valid and dirty, and from IDLE to SWAP_IN otherwise.
REQ-026 SHALL hold SWAP_OUT with mem_wr_req=1 and mem_addr={victim tag, set} until mem_gnt, then go to SWAP_IN.
REQ-027 SHALL hold SWAP_IN with mem_rd_req=1 and mem_addr=latched fill address until mem_gnt, then go to SWAP_IN_OK.
REQ-028 SHALL, in SWAP_IN_OK, write the fill line, tag, valid=1 and dirty=0 into the victim way, mark it MRU and return to IDLE; the retried request then hits.
REQ-029 SHALL keep mem_rd_req and mem_wr_req mutually exclusive and SHALL drive mem_addr=0 when both are low.
REQ-030 SHALL track LRU per set with log2(WAY_CNT)-bit ages: the accessed way goes to 0, ways younger than it increment, and the other ages are unchanged.
REQ-031 SHALL, when WAY_CNT=1, degenerate to direct-mapped with victim way 0.
REQ-032 SHALL ignore any request that drops during a swap; the fill still completes.
REQ-033 SHALL ignore mem_gnt in IDLE and SWAP_IN_OK.

Reset
REQ-034 SHALL, on asserting rst_n=0 at any time including mid-swap, force IDLE, clear every valid and dirty bit, set ages to way index, and drive mem_rd_req=0, mem_wr_req=0 and mem_addr=0.
REQ-035 SHALL leave data and tag arrays unreset; rd_data is undefined until first fill.
REQ-036 SHALL drive miss equal to rd_req|wr_req after reset.

Configuration
REQ-037 SHALL, with CACHE_STATS_EN defined, add 32-bit outputs hit_cnt and miss_cnt that reset to 0, wrap at 2^32, increment once per served hit and once per IDLE-to-swap transition, and freeze during reset.
REQ-038 SHALL, without CACHE_STATS_EN, omit these ports and their logic entirely.

Structure
REQ-039 SHALL place the state enum cache_state_t and the default parameter constants in package cache_pkg.
REQ-040 SHALL implement the per-set age update and victim selection in sub-module cache_lru, parametrised by WAY_CNT.

Verification
REQ-041 SHALL check: cold read of addr 0x100 -> miss=1, SWAP_IN with mem_addr=0x008, then a hit returning mem_rd_line word 0.
REQ-042 SHALL check: a write hit of 0xDEADBEEF to 0x104 followed by a read of 0x104 -> 0xDEADBEEF with miss=0 and dirty set.
REQ-043 SHALL check: five distinct tags in set 0 with WAY_CNT=4, no reaccess -> the first tag is evicted and its dirty line is written back with mem_wr_req before mem_rd_req.
REQ-044 SHALL check: access tags A,B,C,D, then A, then new E -> B is evicted.
REQ-045 SHALL check: rst_n low during SWAP_OUT with mem_gnt withheld -> IDLE next cycle, request lines 0, and a subsequent read of an old address misses.
REQ-046 SHALL check, with CACHE_STATS_EN: 3 misses and 5 hits -> miss_cnt=3 and hit_cnt=5.
